// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream and writes it into
// the instruction memory, one 32-bit word at a time. The CPU is held in reset
// until the whole image has been written.
//
// Byte stream: a 4-byte word count N, then N instruction words. Every value
// arrives big-endian, so the first byte becomes bits [31:24].
//
// Byte handshake: the source drives in_data and raises in_valid. A byte moves
// only on a rising clock edge where in_valid && in_ready are both high. While
// in_ready is low the source keeps the same byte on in_data, and that byte is
// not taken.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 11
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_CHK   = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t           state, next_state;
    logic [1:0]       byte_cnt;
    logic [31:0]      shreg;
    logic [CNT_W-1:0] n_words;
    logic             take;
    logic             last_byte;

    // Next values of the registered outputs
    logic             in_ready_d, mem_we_d, cpu_hold_d, done_d, error_d;
    logic [31:0]      mem_addr_d, mem_wdata_d;
    logic [CNT_W-1:0] words_loaded_d;

    assign take      = in_valid && in_ready;
    assign last_byte = take && (byte_cnt == 2'd3);
    assign dbg_state = state;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; start is only honoured in IDLE, DONE and ERR
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_HDR;
            S_HDR:   if (last_byte) next_state = S_CHK;
            S_CHK: begin
                if (shreg > DEPTH_W)    next_state = S_ERR;
                else if (shreg == '0)   next_state = S_DONE;
                else                    next_state = S_DATA;
            end
            S_DATA:  if (last_byte) next_state = S_WRITE;
            S_WRITE: begin
                if ((words_loaded + CNT_W'(1)) == n_words) next_state = S_DONE;
                else                                       next_state = S_DATA;
            end
            S_DONE, S_ERR: if (start) next_state = S_HDR;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic: next values, derived from the state being entered, so that
    // every output is registered and lines up with its state
    always_comb begin
        in_ready_d     = (next_state == S_HDR) || (next_state == S_DATA);
        mem_we_d       = (next_state == S_WRITE);
        cpu_hold_d     = (next_state != S_DONE);
        done_d         = (next_state == S_DONE);
        error_d        = (next_state == S_ERR);
        mem_addr_d     = mem_addr;
        mem_wdata_d    = mem_wdata;
        words_loaded_d = words_loaded;
        if (state == S_DATA && next_state == S_WRITE) begin
            mem_addr_d  = 32'(words_loaded) << 2;
            mem_wdata_d = {shreg[23:0], in_data};
        end
        if (state == S_WRITE)
            words_loaded_d = words_loaded + CNT_W'(1);
        else if (next_state == S_HDR && state != S_HDR)
            words_loaded_d = '0;
    end

    // Output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            in_ready     <= in_ready_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            cpu_hold     <= cpu_hold_d;
            done         <= done_d;
            error        <= error_d;
            words_loaded <= words_loaded_d;
        end
    end

    // Byte assembly. The byte counter restarts on every state change, so no
    // partial word survives into the next phase or the next load. The header
    // count is saved during CHK, before DATA starts overwriting the shift register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            byte_cnt <= '0;
            shreg    <= '0;
            n_words  <= '0;
        end else begin
            if (next_state != state) byte_cnt <= '0;
            else if (take)           byte_cnt <= byte_cnt + 2'd1;
            if (take)                shreg    <= {shreg[23:0], in_data};
            if (state == S_CHK)      n_words  <= shreg[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. It drives byte streams with and without random
// gaps and compares every memory write against a word list that the bench
// builds from each image.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int CNT_W = 11;

    // ---------------- clock / reset ----------------
    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready, mem_we, cpu_hold, done, error;
    logic [31:0]      mem_addr, mem_wdata;
    logic [CNT_W-1:0] words_loaded;
    logic [2:0]       dbg_state;

    always #5 Clk = ~Clk;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_loaded(words_loaded),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_assert = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [31:0] img[DEPTH];
    int          cyc = 0;
    int          last_acc_cyc = -100;
    int          acc_bytes = 0;
    logic [31:0] last_got_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples 2 time units before each rising edge. It records writes
    // and accepted bytes, and checks write latency and in_ready during WRITE.
    always begin
        @(negedge Clk);
        #3;
        cyc++;
        if (Rst_n === 1'b1 && mem_we === 1'b1) begin
            got_q.push_back({mem_addr, mem_wdata});
            last_got_addr = mem_addr;
            check("we_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("we_latency", 32'(cyc - last_acc_cyc), 32'd1);
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            acc_bytes++;
            last_acc_cyc = cyc;
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // All driver activity happens 1 time unit after a falling edge.
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        int budget;
        g = gaps ? int'($urandom_range(0, 3)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 50;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        check("byte_handshake", {31'd0, in_ready}, 32'd1);
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gaps);
    endtask

    task automatic wait_end();
        int budget;
        budget = 40;
        while (!(done || error) && budget > 0) begin
            tick();
            budget--;
        end
        check("wait_end", {31'd0, done | error}, 32'd1);
    endtask

    task automatic compare_writes(input string tag);
        logic [63:0] e, g;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, "_addr"}, g[63:32], e[63:32]);
            check({tag, "_data"}, g[31:0], e[31:0]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // Full load of img[0..n-1]: expected writes are word i at byte address 4*i
    task automatic run_load(input string tag, input int n, input bit gaps, input bit start_mid);
        int acc0;
        acc0 = acc_bytes;
        pulse_start();
        check({tag, "_start_wl"},   32'(words_loaded), 32'd0);
        check({tag, "_start_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_start_flag"}, {30'd0, done, error}, 32'd0);
        check({tag, "_start_rdy"},  {31'd0, in_ready}, 32'd1);
        send_word(32'(n), gaps);
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({32'(w * 4), img[w]});
            send_word(img[w], gaps);
            if (start_mid && w == 0) begin
                in_valid = 1'b0;
                pulse_start();
            end
        end
        in_valid = 1'b0;
        wait_end();
        check({tag, "_done"},  {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
        check({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
        check({tag, "_wl"},    32'(words_loaded), 32'(n));
        check({tag, "_bytes"}, 32'(acc_bytes - acc0), 32'(4 + 4 * n));
        compare_writes(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
        check({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"},  mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
        check({tag, "_flags"}, {30'd0, done, error}, 32'd0);
        check({tag, "_wl"},    32'(words_loaded), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int budget;
        int n;

        // Reset
        tick();
        tick();
        check_reset_vals("reset");
        Rst_n = 1'b1;
        tick();
        check("idle_rdy", {31'd0, in_ready}, 32'd0);
        check("idle_hold", {31'd0, cpu_hold}, 32'd1);

        // Two-word image
        img[0] = 32'h12345678;
        img[1] = 32'h9ABCDEF0;
        run_load("t1", 2, 1'b0, 1'b0);

        // Empty image: done with no write
        run_load("t2", 0, 1'b0, 1'b0);

        // Header 1025 exceeds DEPTH
        pulse_start();
        send_word(32'd1025, 1'b0);
        in_valid = 1'b0;
        wait_end();
        check("t3_error", {31'd0, error}, 32'd1);
        check("t3_done",  {31'd0, done}, 32'd0);
        check("t3_hold",  {31'd0, cpu_hold}, 32'd1);
        check("t3_rdy",   {31'd0, in_ready}, 32'd0);
        check("t3_nowr",  32'(got_q.size()), 32'd0);
        tick();
        check("t3_stay_err", {31'd0, error}, 32'd1);
        pulse_start();
        check("t3_restart_err", {31'd0, error}, 32'd0);
        check("t3_restart_rdy", {31'd0, in_ready}, 32'd1);
        check("t3_restart_hold", {31'd0, cpu_hold}, 32'd1);
        // The start pulse inside run_load lands in HDR and is ignored
        run_load("t3b", 0, 1'b0, 1'b0);

        // N=3 without and with random gaps: both must give the same writes
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        run_load("t4_nogap", 3, 1'b0, 1'b0);
        run_load("t4_gap", 3, 1'b1, 1'b0);

        // Random loads; a start pulse during WRITE must be ignored
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_load("rand", n, 1'b1, (r % 2) == 0);
        end

        // Reset in the middle of an N=4 load, after word 2 is written
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        pulse_start();
        send_word(32'd4, 1'b0);
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back({32'(w * 4), img[w]});
            send_word(img[w], 1'b1);
        end
        in_valid = 1'b0;
        budget = 20;
        while (words_loaded != 11'd2 && budget > 0) begin
            tick();
            budget--;
        end
        check("t5_two_written", 32'(words_loaded), 32'd2);
        #1;
        Rst_n = 1'b0;
        #1;
        check_reset_vals("t5_async");
        compare_writes("t5_partial");
        @(negedge Clk);
        #1;
        Rst_n = 1'b1;
        tick();
        check("t5_idle_rdy", {31'd0, in_ready}, 32'd0);
        img[0] = $urandom;
        run_load("t5_reload", 1, 1'b0, 1'b0);

        // Full-depth image
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        run_load("t6", DEPTH, 1'b0, 1'b0);
        check("t6_last_addr", last_got_addr, 32'h00000FFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
